// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends a shared counter4 to one of two requesters and
// times a per-requester terminal count. Optional overrun checking: TIMER_ARB_ERR_CHECK_EN.
module timer_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [3:0] cnt_count,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       cnt_enable,
    output logic       cnt_reset_n,
`ifdef TIMER_ARB_ERR_CHECK_EN
    output logic       err,
`endif
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] len_q, len_d;
    logic       last_q, last_d;   // index of the requester served most recently
    logic       run_en;
    logic       win;
    logic       g_idx;
    logic       req_g;
`ifdef TIMER_ARB_ERR_CHECK_EN
    logic       err_q, err_d;
`endif

    // With both requesting, the one not served last wins.
    assign win   = (req == 2'b11) ? ~last_q : req[1];
    assign g_idx = grant_q[1];
    assign req_g = |(req & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        len_d   = len_q;
        last_d  = last_q;
        run_en  = 1'b0;
`ifdef TIMER_ARB_ERR_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    len_d   = win ? len1 : len0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!req_g) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = g_idx;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!req_g) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = g_idx;
`ifdef TIMER_ARB_ERR_CHECK_EN
                end else if (cnt_count > len_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = g_idx;
`endif
                end else begin
                    run_en = (cnt_count != len_q);
                    if (cnt_count == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
                last_d  = g_idx;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            len_q   <= 4'd0;
            last_q  <= 1'b1;
`ifdef TIMER_ARB_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            last_q  <= last_d;
`ifdef TIMER_ARB_ERR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs are gated by reset so the counter is held clear for the whole reset window.
    assign grant       = reset ? 2'b00 : grant_q;
    assign done        = (!reset && state_q == DONE) ? grant_q : 2'b00;
    assign cnt_enable  = !reset && run_en;
    assign cnt_reset_n = !reset && (state_q != CLEAR);
    assign state_dbg   = state_q;
`ifdef TIMER_ARB_ERR_CHECK_EN
    assign err         = err_q;
`endif

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock, shared with the sequenced counter4 instance.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req  input  2  per-requester request level, bit i = requester i; held high until done[i] or abort.
REQ-005 len0  input  4  requester 0 terminal count, sampled at grant.
REQ-006 len1  input  4  requester 1 terminal count, sampled at grant.
REQ-007 grant  output  2  one-hot owner of the counter; 00 when idle.
REQ-008 done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 cnt_enable  output  1  drives counter4 enable.
REQ-010 cnt_reset_n  output  1  drives counter4 reset_n, active-low clear.
REQ-011 cnt_count  input  4  counter4 count value.

Function
REQ-012 FSM states SHALL be IDLE, CLEAR, RUN and DONE.
REQ-013 In IDLE with req!=00, the block SHALL pick a winner and latch its len into len_q; it SHALL set grant one-hot and go to CLEAR on the same edge.
REQ-014 Arbitration SHALL be round-robin: when both bits of req are high, the requester not served last wins; after reset, requester 0 has priority.
REQ-015 In CLEAR (exactly one cycle), cnt_reset_n SHALL be 0 and cnt_enable 0; next state is RUN.
REQ-016 In RUN, cnt_enable SHALL be combinational: (cnt_count != len_q), so the counter stops exactly at len_q.
REQ-017 In RUN, when cnt_count == len_q, next state SHALL be DONE.
REQ-018 In DONE (one cycle), done[g] SHALL be 1 for granted g, cnt_enable 0; next edge clears grant, records g as last served, and returns to IDLE.
REQ-019 Latency: if edge E0 samples req in IDLE, then:
  - grant is high from E0 through the cycle after E(len_q+2);
  - cnt_enable is high for exactly len_q cycles;
  - done is high in the cycle after E(len_q+2).
REQ-020 len_q=0 SHALL skip counting: RUN is one cycle with cnt_enable 0, and DONE follows after E2.
REQ-021 len_q=15 SHALL count to 15 and stop with no wrap.
REQ-022 If req[g] drops during CLEAR or RUN, the block SHALL abort: return to IDLE on the next edge, grant=00, no done pulse, cnt_enable forced 0 in that cycle, last served updated to g.
REQ-023 A req[g] low during DONE SHALL NOT suppress the done pulse.
REQ-024 len0/len1 changes after grant SHALL have no effect until the next grant.
REQ-025 A new request SHALL NOT be granted in the DONE cycle; earliest regrant is in the IDLE cycle following DONE.
REQ-026 cnt_reset_n SHALL be 1 in all states except CLEAR and reset.

Reset
REQ-027 While reset=1, the following SHALL hold:
  - state=IDLE, grant=00, done=00;
  - cnt_enable=0, cnt_reset_n=0 (counter held clear);
  - len_q=0, last served = requester 1 (so requester 0 wins first).
REQ-028 Reset SHALL override all other events, including reset asserted mid-RUN or in DONE; no done pulse is issued for the interrupted transaction.
REQ-029 In the first cycle after reset deasserts, the block SHALL be in IDLE with cnt_reset_n=1.

Configuration
REQ-030 Macro TIMER_ARB_ERR_CHECK_EN defined: adds output err (1 bit).
  - err sets sticky when in RUN and cnt_count > len_q.
  - Same edge: abort to IDLE with no done pulse.
  - err clears only on reset.
REQ-031 Macro TIMER_ARB_ERR_CHECK_EN undefined: err port absent; cnt_count > len_q is ignored and RUN continues with cnt_enable 1 until cnt_count == len_q.

Verification
REQ-032 Reset, then req=01, len0=3 held:
  - grant=01 after E0; cnt_reset_n low for one cycle;
  - cnt_enable high 3 cycles; count ends at 3;
  - done=01 after E5, grant=00 after E6.
REQ-033 req=11, len0=2, len1=5 from reset:
  - requester 0 served first, done=01;
  - requester 1 granted in the IDLE cycle after, counts to 5, done=10;
  - a further req=11 then grants requester 0.
REQ-034 len1=0 on a lone req=10: done=10 after E2; cnt_enable never high.
REQ-035 req=01, len0=15; deassert req at count=7:
  - no done; grant=00 the next cycle;
  - count holds at 7; next req=11 grants requester 1.
REQ-036 reset=1 mid-RUN at count=4: the next cycle shows grant=00, done=00, cnt_reset_n=0, cnt_enable=0.
REQ-037 With TIMER_ARB_ERR_CHECK_EN, len0=2, and the bench forcing cnt_count=9 during RUN: err=1 the next cycle and stays high; no done pulse.
